// File: rtl/even_parity_gen.sv
// Even-parity generator/checker: combinational parity of data_in, a registered
// {data, parity} word for the link, and a receive-side checker with saturating error count.
module even_parity_gen #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 in_valid,
  output logic                 parity,
  output logic [DATA_W:0]      data_out,
  output logic                 out_valid,
  input  logic [DATA_W:0]      chk_in,
  input  logic                 chk_valid,
  output logic                 chk_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // XOR reduction; a leading zero pad lets one helper serve both data and received words.
  function automatic logic odd_ones_f(input logic [DATA_W:0] word);
    odd_ones_f = ^word;
  endfunction

  logic                 data_par_s;
  logic                 chk_bad_s;
  logic                 cnt_sat_s;
  logic [DATA_W:0]      data_out_r;
  logic                 out_valid_r;
  logic                 chk_err_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  assign data_par_s = odd_ones_f({1'b0, data_in});
  assign chk_bad_s  = odd_ones_f(chk_in);
  assign cnt_sat_s  = &err_count_r;

  assign parity    = data_par_s;
  assign data_out  = data_out_r;
  assign out_valid = out_valid_r;
  assign chk_err   = chk_err_r;
  assign err_count = err_count_r;

  // Generate path: capture {data, parity} when in_valid, otherwise hold the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      data_out_r  <= {data_in, data_par_s};
      out_valid_r <= 1'b1;
    end else begin
      data_out_r  <= data_out_r;
      out_valid_r <= 1'b0;
    end
  end

  // Check path: flag odd words and count them, pinning the counter at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_r   <= 1'b0;
      err_count_r <= '0;
    end else if (chk_valid) begin
      chk_err_r <= chk_bad_s;
      if (chk_bad_s && !cnt_sat_s) begin
        err_count_r <= err_count_r + ERR_CNT_W'(1);
      end else begin
        err_count_r <= err_count_r;
      end
    end else begin
      chk_err_r   <= 1'b0;
      err_count_r <= err_count_r;
    end
  end

endmodule

// File: tb/tb_even_parity_gen.sv
// Randomized self-checking bench for even_parity_gen: default instance plus a
// 2-bit-counter instance for saturation, both compared against a counting model.
module tb_even_parity_gen;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       in_valid;
  logic [8:0] chk_in;
  logic       chk_valid;

  logic        parity_a, out_valid_a, chk_err_a;
  logic [8:0]  data_out_a;
  logic [15:0] err_count_a;
  logic        parity_b, out_valid_b, chk_err_b;
  logic [8:0]  data_out_b;
  logic [1:0]  err_count_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [8:0] e_dout;
  logic       e_ov;
  logic       e_err;
  int         e_cnt_a;
  int         e_cnt_b;

  even_parity_gen #(.DATA_W(8), .ERR_CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .parity(parity_a), .data_out(data_out_a), .out_valid(out_valid_a),
    .chk_in(chk_in), .chk_valid(chk_valid), .chk_err(chk_err_a),
    .err_count(err_count_a)
  );

  even_parity_gen #(.DATA_W(8), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .parity(parity_b), .data_out(data_out_b), .out_valid(out_valid_b),
    .chk_in(chk_in), .chk_valid(chk_valid), .chk_err(chk_err_b),
    .err_count(err_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic odd_count(input logic [31:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  // One clock: drive inputs, check parity, advance the model, check registered outputs.
  task automatic cycle(input logic r, input logic [7:0] d, input logic iv,
                       input logic [8:0] c, input logic cv);
    logic bad;
    rst = r; data_in = d; in_valid = iv; chk_in = c; chk_valid = cv;
    #1;
    check_val("parity_a", 32'(parity_a), 32'(odd_count(32'(d))));
    check_val("parity_b", 32'(parity_b), 32'(odd_count(32'(d))));
    @(posedge clk);
    if (r) begin
      e_dout = 9'h000; e_ov = 1'b0; e_err = 1'b0; e_cnt_a = 0; e_cnt_b = 0;
    end else begin
      if (iv) begin
        e_dout = {d, odd_count(32'(d))};
        e_ov   = 1'b1;
      end else begin
        e_ov = 1'b0;
      end
      if (cv) begin
        bad   = odd_count(32'(c));
        e_err = bad;
        if (bad) begin
          e_cnt_a = (e_cnt_a < 65535) ? e_cnt_a + 1 : e_cnt_a;
          e_cnt_b = (e_cnt_b < 3) ? e_cnt_b + 1 : e_cnt_b;
        end
      end else begin
        e_err = 1'b0;
      end
    end
    @(negedge clk);
    check_val("data_out_a",  32'(data_out_a),  32'(e_dout));
    check_val("out_valid_a", 32'(out_valid_a), 32'(e_ov));
    check_val("chk_err_a",   32'(chk_err_a),   32'(e_err));
    check_val("err_count_a", 32'(err_count_a), 32'(e_cnt_a));
    check_val("data_out_b",  32'(data_out_b),  32'(e_dout));
    check_val("out_valid_b", 32'(out_valid_b), 32'(e_ov));
    check_val("chk_err_b",   32'(chk_err_b),   32'(e_err));
    check_val("err_count_b", 32'(err_count_b), 32'(e_cnt_b));
  endtask

  logic [7:0] par_vec [8] = '{8'h00, 8'h18, 8'hE0, 8'h28, 8'h3E, 8'hA8, 8'hA0, 8'h7C};
  logic       par_exp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int         sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1; data_in = 8'h00; in_valid = 1'b0; chk_in = 9'h000; chk_valid = 1'b0;
    e_dout = 9'h000; e_ov = 1'b0; e_err = 1'b0; e_cnt_a = 0; e_cnt_b = 0;

    // Combinational parity table, 10 ns per step
    for (int i = 0; i < 8; i++) begin
      data_in = par_vec[i];
      #1;
      check_val("parity_table", 32'(parity_a), 32'(par_exp[i]));
      #9;
    end

    @(negedge clk);
    cycle(1'b1, 8'h00, 1'b0, 9'h000, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 9'h000, 1'b0);
    check_val("reset_data_out", 32'(data_out_a), 32'h0);
    check_val("reset_out_valid", 32'(out_valid_a), 32'h0);

    // Generate path
    cycle(1'b0, 8'hE0, 1'b1, 9'h000, 1'b0);
    check_val("gen_word", 32'(data_out_a), 32'h1C1);
    check_val("gen_valid", 32'(out_valid_a), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 9'h000, 1'b0);
    check_val("gen_hold", 32'(data_out_a), 32'h1C1);
    check_val("gen_valid_drop", 32'(out_valid_a), 32'h0);

    // Good and bad received words
    cycle(1'b0, 8'h00, 1'b0, 9'b000110000, 1'b1);
    check_val("good1_err", 32'(chk_err_a), 32'h0);
    cycle(1'b0, 8'h00, 1'b0, 9'b111000001, 1'b1);
    check_val("good2_err", 32'(chk_err_a), 32'h0);
    check_val("good_cnt", 32'(err_count_a), 32'h0);
    cycle(1'b0, 8'h00, 1'b0, 9'b111000000, 1'b1);
    check_val("bad_err", 32'(chk_err_a), 32'h1);
    check_val("bad_cnt", 32'(err_count_a), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 9'b111000000, 1'b0);
    check_val("idle_err", 32'(chk_err_a), 32'h0);
    check_val("idle_cnt", 32'(err_count_a), 32'h1);

    // Saturation of the 2-bit counter
    cycle(1'b1, 8'h00, 1'b0, 9'h000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 9'h001, 1'b1);
      check_val("sat_seq", 32'(err_count_b), 32'(sat_exp[i]));
    end

    // Reset mid-operation
    cycle(1'b1, 8'h00, 1'b0, 9'h000, 1'b0);
    cycle(1'b0, 8'h11, 1'b1, 9'h100, 1'b1);
    cycle(1'b0, 8'h12, 1'b1, 9'h003, 1'b0);
    cycle(1'b0, 8'h13, 1'b1, 9'h007, 1'b1);
    check_val("pre_rst_valid", 32'(out_valid_a), 32'h1);
    check_val("pre_rst_cnt", 32'(err_count_a), 32'h2);
    cycle(1'b1, 8'h3E, 1'b1, 9'h001, 1'b1);
    check_val("rst_parity", 32'(parity_a), 32'h1);
    check_val("rst_data_out", 32'(data_out_a), 32'h0);
    check_val("rst_valid", 32'(out_valid_a), 32'h0);
    check_val("rst_err", 32'(chk_err_a), 32'h0);
    check_val("rst_cnt", 32'(err_count_a), 32'h0);
    cycle(1'b0, 8'h01, 1'b1, 9'h001, 1'b1);
    check_val("post_rst_word", 32'(data_out_a), 32'h003);
    check_val("post_rst_cnt", 32'(err_count_a), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 31) == 0), 8'($urandom), 1'($urandom),
            9'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
